// File: rtl/fb_pkg.sv
// Shared types, defaults and colour packing for the frame buffer write path.
package fb_pkg;

  localparam int H_SIZE_DEF     = 256;
  localparam int V_SIZE_DEF     = 240;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    LINE_WAIT = 2'd2,
    FRAME_END = 2'd3
  } fb_state_e;

  // RGB888 -> RGB444: keep the top nibble of each channel.
  function automatic logic [11:0] pack_rgb444(input logic [23:0] c);
    return {4'(c[23:16] >> 4), 4'(c[15:8] >> 4), 4'(c[7:0] >> 4)};
  endfunction

endpackage

// File: rtl/fb_if.sv
// PPU pixel stream in, frame buffer write port and status out.
interface fb_if
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [23:0]           pixel_color;
  logic                  pixel_valid;
  logic                  vsync;
  logic                  hsync;
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_bank;
  logic                  frame_done;
  logic                  sync_err;

  // Pixel source / observer side.
  modport master (
    output pixel_color, pixel_valid, vsync, hsync,
    input  wr_en, wr_addr, wr_data, rd_bank, frame_done, sync_err
  );

  // Write controller side.
  modport slave (
    input  pixel_color, pixel_valid, vsync, hsync,
    output wr_en, wr_addr, wr_data, rd_bank, frame_done, sync_err
  );
endinterface

// File: rtl/fb_pixel_counter.sv
// Pixel/line position tracking with a linear (y*H_SIZE+x) write address.
module fb_pixel_counter
  import fb_pkg::*;
#(
  parameter int H_SIZE     = H_SIZE_DEF,
  parameter int V_SIZE     = V_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  adv,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] lin_addr,
  output logic                  last_pixel,
  output logic                  last_line
);
  localparam int XW = $clog2(H_SIZE);
  localparam int YW = $clog2(V_SIZE);

  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] line_base;  // y*H_SIZE, kept as a running sum

  assign last_pixel = (x == XW'(H_SIZE - 1));
  assign last_line  = (y == YW'(V_SIZE - 1));

  // Line advance jumps to the next line start, so short lines leave a hole.
  // The last pixel of a line holds the counters, keeping lin_addr in range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x         <= '0;
      y         <= '0;
      lin_addr  <= '0;
      line_base <= '0;
    end else if (clr) begin
      x         <= '0;
      y         <= '0;
      lin_addr  <= '0;
      line_base <= '0;
    end else if (adv) begin
      x         <= '0;
      y         <= y + YW'(1);
      line_base <= line_base + ADDR_WIDTH'(H_SIZE);
      lin_addr  <= line_base + ADDR_WIDTH'(H_SIZE);
    end else if (inc && !last_pixel) begin
      x         <= x + XW'(1);
      lin_addr  <= lin_addr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/frame_buffer_write_ctrl.sv
// Writes the PPU pixel stream into the back bank and swaps banks per frame.
module frame_buffer_write_ctrl
  import fb_pkg::*;
#(
  parameter int H_SIZE     = H_SIZE_DEF,
  parameter int V_SIZE     = V_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic  clk,
  input logic  rst,
  fb_if.slave  bus
);
  fb_state_e             state, state_nxt;
  logic                  clr, adv, inc;
  logic                  wr_nxt, err_nxt, done_nxt;
  logic                  last_pixel, last_line;
  logic [ADDR_WIDTH-1:0] lin_addr;

  logic                  wr_en_q, rd_bank_q, frame_done_q, sync_err_q;
  logic [ADDR_WIDTH:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  fb_pixel_counter #(
    .H_SIZE     (H_SIZE),
    .V_SIZE     (V_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .adv        (adv),
    .inc        (inc),
    .lin_addr   (lin_addr),
    .last_pixel (last_pixel),
    .last_line  (last_line)
  );

  // Next state and counter controls; vsync outranks hsync, syncs outrank pixels.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    adv       = 1'b0;
    inc       = 1'b0;
    wr_nxt    = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.vsync) begin
          state_nxt = ACTIVE;
          clr       = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.vsync) begin
          clr     = 1'b1;
          err_nxt = 1'b1;
        end else if (bus.hsync) begin
          // Short line; on the last line the frame is dropped without a swap.
          err_nxt = 1'b1;
          if (last_line) begin
            state_nxt = IDLE;
            clr       = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end else if (bus.pixel_valid) begin
          inc    = 1'b1;
          wr_nxt = 1'b1;
          if (last_pixel) state_nxt = last_line ? FRAME_END : LINE_WAIT;
        end
      end
      LINE_WAIT: begin
        if (bus.vsync) begin
          state_nxt = ACTIVE;
          clr       = 1'b1;
          err_nxt   = 1'b1;
        end else if (bus.hsync) begin
          state_nxt = ACTIVE;
          adv       = 1'b1;
        end
      end
      FRAME_END: begin
        done_nxt  = 1'b1;
        state_nxt = bus.vsync ? ACTIVE : IDLE;
        clr       = bus.vsync;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered write port and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_bank_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_en_q      <= wr_nxt;
      frame_done_q <= done_nxt;
      sync_err_q   <= err_nxt;
      if (done_nxt) rd_bank_q <= ~rd_bank_q;
      if (wr_nxt) begin
        wr_addr_q <= {~rd_bank_q, lin_addr};
        wr_data_q <= DATA_WIDTH'(pack_rgb444(bus.pixel_color));
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_frame_buffer_write_ctrl.sv
// Directed + randomized bench for frame_buffer_write_ctrl with a frame-level model.
module tb_frame_buffer_write_ctrl;
  localparam int H = 256;
  localparam int V = 240;

  logic clk;
  logic rst;
  fb_if bus_i ();

  frame_buffer_write_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: where we are in the frame, in plain pixel/line terms.
  bit m_run, m_wait, m_end, m_bank;
  int m_x, m_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_wait = 0; m_end = 0; m_bank = 0; m_x = 0; m_y = 0;
  endtask

  // One clock: drive inputs, predict, then check registered outputs after the edge.
  task automatic step(input bit v, input bit vs, input bit hs, input logic [23:0] col);
    bit   e_we, e_err, e_done;
    int   e_addr;
    logic [11:0] e_data;
    e_we = 0; e_err = 0; e_done = 0; e_addr = 0; e_data = '0;
    bus_i.pixel_valid = v;
    bus_i.vsync       = vs;
    bus_i.hsync       = hs;
    bus_i.pixel_color = col;
    if (m_end) begin
      e_done = 1; m_bank = ~m_bank; m_end = 0;
      m_run = vs; m_wait = 0; m_x = 0; m_y = 0;
    end else if (vs) begin
      e_err = m_run; m_run = 1; m_wait = 0; m_x = 0; m_y = 0;
    end else if (m_run && hs) begin
      if (!m_wait) e_err = 1;
      if (!m_wait && m_y == V - 1) m_run = 0;
      else begin m_y++; m_x = 0; m_wait = 0; end
    end else if (m_run && !m_wait && v) begin
      e_we   = 1;
      e_addr = ((m_bank ? 0 : 1) << 16) | (m_y * H + m_x);
      e_data = {col[23:20], col[15:12], col[7:4]};
      m_x++;
      if (m_x == H) begin
        if (m_y == V - 1) begin m_end = 1; m_run = 0; end
        else m_wait = 1;
      end
    end
    @(posedge clk); #1;
    chk("wr_en", 32'(bus_i.wr_en), 32'(e_we));
    if (e_we) begin
      chk("wr_addr", 32'(bus_i.wr_addr), e_addr);
      chk("wr_data", 32'(bus_i.wr_data), 32'(e_data));
    end
    chk("sync_err", 32'(bus_i.sync_err), 32'(e_err));
    chk("frame_done", 32'(bus_i.frame_done), 32'(e_done));
    chk("rd_bank", 32'(bus_i.rd_bank), 32'(m_bank));
  endtask

  // n accepted pixels, random colours unless fixed, with optional idle gaps.
  task automatic pixels(input int n, input int gap_pct, input bit fixed, input logic [23:0] col);
    int k = 0;
    while (k < n) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) step(0, 0, 0, 24'($urandom()));
      else begin
        step(1, 0, 0, fixed ? col : 24'($urandom()));
        k++;
      end
    end
  endtask

  // Line gap with stray pixel_valid, then hsync.
  task automatic next_line();
    int g = $urandom_range(2);
    for (int i = 0; i < g; i++) step(1'($urandom_range(1)), 0, 0, 24'($urandom()));
    step(0, 0, 1, 24'h0);
  endtask

  // Hop lines quickly with one pixel and a short-line hsync each.
  task automatic jump_to(input int line);
    while (m_y < line) begin
      step(1, 0, 0, 24'($urandom()));
      step(0, 0, 1, 24'h0);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus_i.pixel_valid = 0; bus_i.vsync = 0; bus_i.hsync = 0; bus_i.pixel_color = '0;
    model_reset();
    repeat (2) @(posedge clk); #1;
    chk("rst_wr_en", 32'(bus_i.wr_en), 0);
    chk("rst_wr_addr", 32'(bus_i.wr_addr), 0);
    chk("rst_wr_data", 32'(bus_i.wr_data), 0);
    chk("rst_rd_bank", 32'(bus_i.rd_bank), 0);
    chk("rst_frame_done", 32'(bus_i.frame_done), 0);
    chk("rst_sync_err", 32'(bus_i.sync_err), 0);
    rst = 1'b1;

    // Idle: pixels and hsync ignored; vsync with a pixel drops that pixel.
    step(1, 0, 1, 24'h123456);
    step(1, 1, 0, 24'hABCDEF);

    // Frame 1, line 0 with a fixed colour, then a full frame.
    pixels(H, 0, 1, 24'hF08040);
    chk("line0_last_addr", 32'(bus_i.wr_addr), 32'h100FF);
    chk("line0_data", 32'(bus_i.wr_data), 32'hF84);
    step(1, 0, 0, 24'h111111);
    for (int l = 1; l < V; l++) begin
      next_line();
      pixels(H, 0, 0, 24'h0);
    end
    chk("frame_last_addr", 32'(bus_i.wr_addr), 32'h1EFFF);
    step(1, 0, 1, 24'h0);
    chk("frame1_done", 32'(bus_i.frame_done), 1);
    chk("frame1_bank", 32'(bus_i.rd_bank), 1);

    // Frame 2 into bank 0, short line on line 5, abort on line 120.
    step(0, 1, 0, 24'h0);
    pixels(1, 0, 0, 24'h0);
    chk("frame2_first_addr", 32'(bus_i.wr_addr), 32'h00000);
    pixels(H - 1, 10, 0, 24'h0);
    for (int l = 1; l < 6; l++) begin
      next_line();
      pixels(l == 5 ? 100 : H, 10, 0, 24'h0);
    end
    step(0, 0, 1, 24'h0);
    chk("short_line_err", 32'(bus_i.sync_err), 1);
    pixels(1, 0, 0, 24'h0);
    chk("short_line_next_addr", 32'(bus_i.wr_addr), 32'd1536);
    jump_to(120);
    pixels(37, 10, 0, 24'h0);
    step(0, 1, 0, 24'h0);
    chk("abort_err", 32'(bus_i.sync_err), 1);
    chk("abort_bank", 32'(bus_i.rd_bank), 1);
    pixels(1, 0, 0, 24'h0);
    chk("abort_next_addr", 32'(bus_i.wr_addr), 32'h00000);

    // vsync + hsync together in LINE_WAIT restarts the frame.
    pixels(H - 1, 0, 0, 24'h0);
    step(0, 1, 1, 24'h0);
    pixels(1, 0, 0, 24'h0);
    chk("vs_hs_next_addr", 32'(bus_i.wr_addr), 32'h00000);

    // Short last line abandons the frame, no swap.
    jump_to(V - 1);
    step(0, 0, 1, 24'h0);
    chk("abandon_bank", 32'(bus_i.rd_bank), 1);
    step(1, 0, 0, 24'h0);

    // Complete a frame with vsync landing in the end cycle.
    step(0, 1, 0, 24'h0);
    jump_to(V - 1);
    pixels(H, 0, 0, 24'h0);
    step(0, 1, 0, 24'h0);
    chk("fe_vsync_done", 32'(bus_i.frame_done), 1);
    chk("fe_vsync_bank", 32'(bus_i.rd_bank), 0);
    pixels(1, 0, 0, 24'h0);
    chk("fe_vsync_next_addr", 32'(bus_i.wr_addr), 32'h10000);
    jump_to(V - 1);
    pixels(H, 0, 0, 24'h0);
    step(0, 0, 0, 24'h0);

    // Reset in mid-line with pixel_valid held high.
    step(0, 1, 0, 24'h0);
    pixels(10, 0, 0, 24'h0);
    bus_i.pixel_valid = 1;
    #3 rst = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(bus_i.wr_en), 0);
    chk("midrst_rd_bank", 32'(bus_i.rd_bank), 0);
    chk("midrst_wr_addr", 32'(bus_i.wr_addr), 0);
    model_reset();
    @(posedge clk); #1;
    chk("midrst_hold_wr_en", 32'(bus_i.wr_en), 0);
    #2 rst = 1'b1;
    repeat (5) step(1, 0, 1, 24'($urandom()));
    step(0, 1, 0, 24'h0);
    pixels(3, 0, 0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
